stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl.sv | 144 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/lap sequencing, 1/100-s prescaler and the
// eight-digit BCD time cascade feeding the seven-segment driver.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | zeroed, waiting for start_stop
//   S_RUN  | counting, display shows live time
//   S_LAP  | counting, display shows the lap latch
//   S_STOP | paused, live time and partial tick held
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] hr_10s,
  output logic [3:0] hr_1s,
  output logic [3:0] min_10s,
  output logic [3:0] min_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] sec_1s,
  output logic [3:0] sec100_10s,
  output logic [3:0] sec100_1s,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  // Packed time {hr_10s .. sec100_1s}; 99:59:59.99 is also the per-digit limit.
  localparam logic [31:0] TIME_MAX = 32'h9959_5999;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [31:0]     live_q, live_d;
  logic [31:0]     lap_q, lap_d;
  logic            running_q, running_d;
  logic            lap_active_q, lap_active_d;
  logic            wrap_q, wrap_d;
  logic            counting;
  logic            tick;

  // Ripple a +0.01 s increment through the digits, each wrapping at its limit.
  function automatic logic [31:0] time_inc(input logic [31:0] t);
    logic [31:0] r;
    logic        carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (t[4*i +: 4] >= TIME_MAX[4*i +: 4]) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = t[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state, prescaler, time cascade and lap latch.
  always_comb begin
    counting = (state_q == S_RUN) || (state_q == S_LAP);
    tick     = counting && (pre_q == PRE_LAST);
    state_d  = state_q;
    pre_d    = pre_q;
    live_d   = live_q;
    lap_d    = lap_q;
    wrap_d   = tick && (live_q == TIME_MAX);

    if (counting) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) live_d = time_inc(live_q);
    end else if (state_q == S_IDLE) begin
      pre_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (start_stop) begin
          state_d = S_STOP;
        end else if (lap) begin
          state_d = S_LAP;
          lap_d   = live_q;
        end
      end
      S_LAP: begin
        if (start_stop) state_d = S_STOP;
        else if (lap)   lap_d   = live_q;
      end
      S_STOP: begin
        if (clear) begin
          state_d = S_IDLE;
          live_d  = '0;
          lap_d   = '0;
          pre_d   = '0;
        end else if (start_stop) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    running_d    = (state_d == S_RUN) || (state_d == S_LAP);
    lap_active_d = (state_d == S_LAP);
  end

  // Register state, counters and status outputs; reset wins over any pulse.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pre_q        <= '0;
      live_q       <= '0;
      lap_q        <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      live_q       <= live_d;
      lap_q        <= lap_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      wrap_q       <= wrap_d;
    end
  end

  assign {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s} =
         lap_active_q ? lap_q : live_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios plus random pulses,
// compared every cycle against a centisecond-integer reference model.
module tb_stopwatch_ctrl;

  localparam int TD    = 4;
  localparam int MAXCS = 100 * 360000;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;

  logic clk_100MHz = 1'b0;
  logic reset = 1'b1, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s;
  logic running, lap_active, wrap;
  logic [31:0] dout;
  logic [31:0] force_val;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int ms = M_IDLE, mcs = 0, mpre = 0, mlatch = 0;
  bit mwrap = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  assign dout = {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s};

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .hr_10s     (hr_10s),
    .hr_1s      (hr_1s),
    .min_10s    (min_10s),
    .min_1s     (min_1s),
    .sec_10s    (sec_10s),
    .sec_1s     (sec_1s),
    .sec100_10s (sec100_10s),
    .sec100_1s  (sec100_1s),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bcd(input int t);
    int h, m, s, c;
    h = t / 360000;
    m = (t / 6000) % 60;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // One clock edge of the behavioural model, using the pulses sampled on it.
  task automatic model_edge(input bit ss, input bit lp, input bit clr, input bit rst);
    bit counting, tk;
    if (rst) begin
      ms = M_IDLE; mcs = 0; mpre = 0; mlatch = 0; mwrap = 1'b0;
      return;
    end
    counting = (ms == M_RUN) || (ms == M_LAP);
    tk       = counting && (mpre == TD - 1);
    mwrap    = tk && (mcs == MAXCS - 1);
    if ((ms == M_RUN || ms == M_LAP) && !ss && lp) mlatch = mcs;
    if (counting) begin
      mpre = tk ? 0 : mpre + 1;
      if (tk) mcs = (mcs + 1) % MAXCS;
    end
    case (ms)
      M_IDLE: if (ss) ms = M_RUN;
      M_RUN:  if (ss) ms = M_STOP; else if (lp) ms = M_LAP;
      M_LAP:  if (ss) ms = M_STOP;
      default: begin
        if (clr) begin
          ms = M_IDLE; mcs = 0; mpre = 0; mlatch = 0;
        end else if (ss) begin
          ms = M_RUN;
        end
      end
    endcase
  endtask

  task automatic step(input bit ss, input bit lp, input bit clr, input bit rst);
    @(negedge clk_100MHz);
    start_stop = ss; lap = lp; clear = clr; reset = rst;
    @(posedge clk_100MHz);
    model_edge(ss, lp, clr, rst);
    #1;
    chk("digits", dout, bcd(ms == M_LAP ? mlatch : mcs));
    chk("running", 32'(running), 32'((ms == M_RUN) || (ms == M_LAP)));
    chk("lap_active", 32'(lap_active), 32'(ms == M_LAP));
    chk("wrap", 32'(wrap), 32'(mwrap));
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0; reset = 1'b0;
  endtask

  // Preload the live time while paused; held across one edge so the flop keeps it.
  task automatic force_live(input int t);
    force_val = bcd(t);
    force dut.live_q = force_val;
    mcs = t;
    step(0, 0, 0, 0);
    release dut.live_q;
  endtask

  initial begin
    int held;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_digits", dout, 32'h0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_lap_active", 32'(lap_active), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);

    // first tick latency and one second
    step(1, 0, 0, 0);
    chk("start_running", 32'(running), 32'd1);
    for (int i = 0; i < TD - 1; i++) step(0, 0, 0, 0);
    chk("pre_first_tick", dout, 32'h0);
    step(0, 0, 0, 0);
    chk("first_tick", dout, 32'h1);
    for (int i = 0; i < 400 - TD; i++) step(0, 0, 0, 0);
    chk("one_second", dout, 32'h100);

    // lap freeze and refresh
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 400 && mcs != 37; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("lap37_active", 32'(lap_active), 32'd1);
    chk("lap37_digits", dout, 32'h37);
    for (int i = 0; i < 200 && mcs != 52; i++) step(0, 0, 0, 0);
    chk("lap37_frozen", dout, 32'h37);
    step(0, 1, 0, 0);
    chk("lap52_digits", dout, 32'h52);

    // pause with partial tick held at 2
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 2 * TD && mpre != 1; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    held = mcs;
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0);
    chk("stop_hold", dout, bcd(held));
    chk("stop_pre", 32'(mpre), 32'd2);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("resume_no_tick", dout, bcd(held));
    step(0, 0, 0, 0);
    chk("resume_tick", dout, bcd(held + 1));

    // clear ignored in RUN and LAP, honoured in STOP
    step(0, 0, 1, 0);
    chk("clr_in_run", 32'(running), 32'd1);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("clr_in_lap", 32'(lap_active), 32'd1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("clr_stop_digits", dout, 32'h0);
    chk("clr_stop_running", 32'(running), 32'd0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3 * TD; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("clr_ss_running", 32'(running), 32'd0);
    chk("clr_ss_digits", dout, 32'h0);
    step(1, 0, 0, 0);
    chk("clr_ss_idle_start", 32'(running), 32'd1);

    // wrap from 99:59:59.98
    step(1, 0, 0, 0);
    force_live(MAXCS - 2);
    chk("force_digits", dout, 32'h9959_5998);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4 * TD && !mwrap; i++) step(0, 0, 0, 0);
    chk("wrap_pulse", 32'(wrap), 32'd1);
    chk("wrap_digits", dout, 32'h0);
    step(0, 0, 0, 0);
    chk("wrap_single", 32'(wrap), 32'd0);
    for (int i = 0; i < TD; i++) step(0, 0, 0, 0);
    chk("wrap_continues", dout, 32'h1);

    // reset while in LAP at 00:01:23.45
    step(1, 0, 0, 0);
    force_live(8345);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("lap_12345", dout, 32'h0001_2345);
    step(1, 1, 1, 1);
    chk("rst_lap_digits", dout, 32'h0);
    chk("rst_lap_running", 32'(running), 32'd0);
    chk("rst_lap_active", 32'(lap_active), 32'd0);

    // random pulse soup
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 4, $urandom_range(0, 999) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finish");
    $fatal(1);
  end

endmodule
